// File: rtl/inst_queue.sv
// inst_queue: line FIFO between icache and decode, slicing up to two
// in-order 32-bit instructions per cycle out of the head line.
module inst_queue #(
  parameter int LINE_DEPTH     = 4,
  parameter int LINE_SIZE      = 512,
  parameter int WORDS_PER_LINE = 16,
  parameter int PTR_WIDTH      = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 icache_valid_i,
  input  logic [63:0]          icache_pc_i,
  input  logic [LINE_SIZE-1:0] icache_data_i,
  output logic                 stall_icache_o,
  output logic                 inst0_valid_o,
  output logic [63:0]          inst0_pc_o,
  output logic [31:0]          inst0_o,
  output logic                 inst1_valid_o,
  output logic [63:0]          inst1_pc_o,
  output logic [31:0]          inst1_o,
  input  logic                 decode_ready_i,
  input  logic                 squash_pipe_i
);
  localparam int WW  = $clog2(WORDS_PER_LINE);
  localparam int PCW = 64 - WW - 2;

  logic [PCW-1:0]       pc_q   [LINE_DEPTH];
  logic [LINE_SIZE-1:0] data_q [LINE_DEPTH];
  logic [WW-1:0]        cw_q   [LINE_DEPTH];
  logic [PTR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PTR_WIDTH:0]   count_q, count_d;
  logic                 push, consume, pop;
  logic [WW-1:0]        cw, cw1;
  logic [WW:0]          cw_sum;
  logic [LINE_SIZE-1:0] head;
  logic                 unused_pc;

  assign unused_pc      = ^icache_pc_i[1:0];
  assign head           = data_q[rptr_q];
  assign cw             = cw_q[rptr_q];
  assign cw1            = cw + WW'(1);
  // Stall looks only at registered occupancy; a same-cycle pop does not free a slot.
  assign stall_icache_o = count_q == (PTR_WIDTH+1)'(LINE_DEPTH);
  assign inst0_valid_o  = count_q != '0 && !squash_pipe_i;
  assign inst1_valid_o  = inst0_valid_o && cw != WW'(WORDS_PER_LINE-1);
  assign inst0_pc_o     = {pc_q[rptr_q], cw, 2'b00};
  assign inst1_pc_o     = inst0_pc_o + 64'd4;
  assign inst0_o        = head[32*cw +: 32];
  assign inst1_o        = head[32*cw1 +: 32];
  assign push           = icache_valid_i && !stall_icache_o && !squash_pipe_i;
  assign consume        = decode_ready_i && inst0_valid_o;
  assign cw_sum         = {1'b0, cw} + (inst1_valid_o ? (WW+1)'(2) : (WW+1)'(1));
  assign pop            = consume && cw_sum == (WW+1)'(WORDS_PER_LINE);

  always_comb begin
    wptr_d  = squash_pipe_i ? '0 : wptr_q + PTR_WIDTH'(push);
    rptr_d  = squash_pipe_i ? '0 : rptr_q + PTR_WIDTH'(pop);
    count_d = squash_pipe_i ? '0 : count_q + (PTR_WIDTH+1)'(push) - (PTR_WIDTH+1)'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Push and partial consume never target the same entry: push needs a free slot.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wptr_q]   <= icache_pc_i[63:WW+2];
      data_q[wptr_q] <= icache_data_i;
      cw_q[wptr_q]   <= icache_pc_i[WW+1:2];
    end
    if (consume && !pop)
      cw_q[rptr_q] <= cw_sum[WW-1:0];
  end
endmodule
